// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared FSM state encoding and default widths for the step scheduler
package sim_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int PRESCALE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        WAIT,
        COMMIT
    } state_t;

endpackage

// File: rtl/sim_step_scheduler_if.sv
// rtl/sim_step_scheduler_if.sv - sample ROM read port and solver start/done handshake
interface sim_step_scheduler_if #(
    parameter int ADDR_W = sim_pkg::ADDR_W,
    parameter int DATA_W = sim_pkg::DATA_W
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              solver_start;
    logic [DATA_W-1:0] solver_operand;
    logic              solver_done;
    logic [DATA_W-1:0] solver_result;

    modport master (
        output rom_addr, solver_start, solver_operand,
        input  rom_data, solver_done, solver_result
    );

    modport slave (
        input  rom_addr, solver_start, solver_operand,
        output rom_data, solver_done, solver_result
    );
endinterface

// File: rtl/sim_tick_gen.sv
// rtl/sim_tick_gen.sv - prescaler down-counter producing the simulation step tick
module sim_tick_gen #(
    parameter int PRESCALE_W = sim_pkg::PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // Holding at prescale while stopped makes the first tick after run rises land a full period later.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || cnt_q == '0) begin
            cnt_d = prescale;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == '0);
endmodule

// File: rtl/sim_step_scheduler.sv
// rtl/sim_step_scheduler.sv - time-step FSM: ROM walk, solver launch, registered step results
// Optional single-step request via SIM_SINGLE_STEP_EN.
module sim_step_scheduler
    import sim_pkg::*;
#(
    parameter int ADDR_W     = sim_pkg::ADDR_W,
    parameter int DATA_W     = sim_pkg::DATA_W,
    parameter int PRESCALE_W = sim_pkg::PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  step,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [ADDR_W-1:0]     end_addr,
    sim_step_scheduler_if.master  bus,
    output logic [DATA_W-1:0]     tensao_saida,
    output logic [DATA_W-1:0]     corrente_saida,
    output logic                  out_valid,
    output logic                  overrun,
    output logic [31:0]           step_count
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] tensao_q, tensao_d;
    logic [DATA_W-1:0] corrente_q, corrente_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       count_q, count_d;

    logic tick;
    logic step_tick;
    logic go;

    sim_tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .prescale (prescale),
        .tick     (tick)
    );

`ifdef SIM_SINGLE_STEP_EN
    // A manual step is only honoured when nothing else could be driving the FSM.
    assign step_tick = step && !run && (state_q == IDLE);
`else
    logic unused_step;
    assign unused_step = step;
    assign step_tick   = 1'b0;
`endif

    assign go = tick || step_tick;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        operand_d  = operand_q;
        start_d    = 1'b0;
        tensao_d   = tensao_q;
        corrente_d = corrente_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q;
        count_d    = count_q;

        // Only prescaler ticks count as overruns; a stray manual step is silently dropped.
        if (tick && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d   = START;
                start_d   = 1'b1;
                operand_d = bus.rom_data;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.solver_done) begin
                    state_d    = COMMIT;
                    valid_d    = 1'b1;
                    tensao_d   = operand_q;
                    corrente_d = bus.solver_result;
                    count_d    = count_q + 32'd1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                addr_d  = (addr_q >= end_addr) ? '0 : addr_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            operand_q  <= '0;
            start_q    <= 1'b0;
            tensao_q   <= '0;
            corrente_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            operand_q  <= operand_d;
            start_q    <= start_d;
            tensao_q   <= tensao_d;
            corrente_q <= corrente_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

    assign bus.rom_addr       = addr_q;
    assign bus.solver_start   = start_q;
    assign bus.solver_operand = operand_q;
    assign tensao_saida       = tensao_q;
    assign corrente_saida     = corrente_q;
    assign out_valid          = valid_q;
    assign overrun            = overrun_q;
    assign step_count         = count_q;
endmodule

// File: tb/tb_sim_step_scheduler.sv
// tb/tb_sim_step_scheduler.sv - directed bench with ROM and fixed-latency divide-by-5 solver models
module tb_sim_step_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [15:0] prescale = 16'd0;
    logic [7:0]  end_addr = 8'd255;
    logic [31:0] tensao_saida;
    logic [31:0] corrente_saida;
    logic        out_valid;
    logic        overrun;
    logic [31:0] step_count;

    sim_step_scheduler_if bus ();

    sim_step_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .step           (step),
        .prescale       (prescale),
        .end_addr       (end_addr),
        .bus            (bus),
        .tensao_saida   (tensao_saida),
        .corrente_saida (corrente_saida),
        .out_valid      (out_valid),
        .overrun        (overrun),
        .step_count     (step_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_val(input logic [7:0] a);
        return 32'(a) * 32'd10 + 32'd10;
    endfunction

    always @(posedge clk) bus.rom_data <= rom_val(bus.rom_addr);

    // Solver: done pulses exactly lat cycles after the start cycle.
    logic [7:0]  lat = 8'd3;
    logic [7:0]  sv_cnt = 8'd0;
    logic [31:0] sv_res = 32'd0;
    always @(posedge clk) begin
        if (bus.solver_start) begin
            sv_cnt <= lat;
            sv_res <= bus.solver_operand / 32'd5;
        end else if (sv_cnt != 8'd0) begin
            sv_cnt <= sv_cnt - 8'd1;
        end
    end
    assign bus.solver_done   = (sv_cnt == 8'd1);
    assign bus.solver_result = sv_res;

    int cyc = 0;
    int ov_tot = 0;
    int st_tot = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid) ov_tot <= ov_tot + 1;
        if (bus.solver_start) st_tot <= st_tot + 1;
    end

    int passed = 0;
    int total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < budget);
        if (!out_valid) begin
            total++;
            $display("FAIL %s: timeout waiting for out_valid", nm);
        end
    endtask

    task automatic wait_start(input string nm, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.solver_start && k < budget);
        if (!bus.solver_start) begin
            total++;
            $display("FAIL %s: timeout waiting for solver_start", nm);
        end
    endtask

    task automatic reset_with(input logic r);
        @(negedge clk);
        rst = 1'b1;
        run = r;
        step = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] pre;
        logic [7:0]  ea;
        logic [7:0]  lt;
        int          n;
        logic [31:0] tens;
        logic [31:0] corr;
        logic [7:0]  addr;
        logic        ov;
    } vec_t;

    vec_t vt [5];

    initial begin
        int t0, ts, v0, s0, exp_steps;
        logic [7:0] exp_addr;

        vt[0] = '{16'd3, 8'd5,   8'd2, 7, 32'd10, 32'd2, 8'd1, 1'b1};
        vt[1] = '{16'd1, 8'd255, 8'd5, 3, 32'd30, 32'd6, 8'd3, 1'b1};
        vt[2] = '{16'd6, 8'd0,   8'd3, 4, 32'd10, 32'd2, 8'd0, 1'b0};
        vt[3] = '{16'd5, 8'd1,   8'd3, 2, 32'd20, 32'd4, 8'd0, 1'b1};
        vt[4] = '{16'd0, 8'd2,   8'd1, 5, 32'd20, 32'd4, 8'd2, 1'b1};

        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_solver_start", 32'(bus.solver_start), 32'd0);
        chk("rst_solver_operand", bus.solver_operand, 32'd0);
        chk("rst_tensao", tensao_saida, 32'd0);
        chk("rst_corrente", corrente_saida, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_step_count", step_count, 32'd0);

        // First-step timing with prescale=9, latency 3
        prescale = 16'd9; end_addr = 8'd255; lat = 8'd3;
        reset_with(1'b1);
        t0 = cyc;
        wait_start("t_start", 20);
        ts = cyc;
        chk("t_start_after_tick", 32'(ts - t0), 32'd2);
        chk("t_operand", bus.solver_operand, 32'd10);
        wait_valid("t_valid", 20);
        chk("t_valid_after_start", 32'(cyc - ts), 32'd4);
        chk("t_tensao", tensao_saida, 32'd10);
        chk("t_corrente", corrente_saida, 32'd2);
        wait_start("t_start2", 20);
        chk("t_step_period", 32'(cyc - ts), 32'd10);

        // Address wrap sequence with end_addr=3
        end_addr = 8'd3;
        reset_with(1'b1);
        for (int k = 0; k < 10; k++) begin
            wait_valid("wrap_valid", 40);
            chk($sformatf("wrap_tensao_%0d", k), tensao_saida, rom_val(8'(k % 4)));
        end
        chk("wrap_step_count", step_count, 32'd10);

        for (int i = 0; i < 5; i++) begin
            prescale = vt[i].pre; end_addr = vt[i].ea; lat = vt[i].lt;
            reset_with(1'b1);
            for (int k = 0; k < vt[i].n; k++) wait_valid($sformatf("v%0d_valid", i), 60);
            chk($sformatf("v%0d_step_count", i), step_count, 32'(vt[i].n));
            chk($sformatf("v%0d_tensao", i), tensao_saida, vt[i].tens);
            chk($sformatf("v%0d_corrente", i), corrente_saida, vt[i].corr);
            @(negedge clk);
            chk($sformatf("v%0d_rom_addr", i), 32'(bus.rom_addr), 32'(vt[i].addr));
            chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'(vt[i].ov));
        end

        // run dropped while in WAIT
        prescale = 16'd9; end_addr = 8'd255; lat = 8'd3;
        reset_with(1'b1);
        wait_start("drop_start", 20);
        @(negedge clk);
        run = 1'b0;
        v0 = ov_tot; s0 = st_tot;
        repeat (40) @(negedge clk);
        chk("drop_out_valids", 32'(ov_tot - v0), 32'd1);
        chk("drop_extra_starts", 32'(st_tot - s0), 32'd0);
        chk("drop_step_count", step_count, 32'd1);
        chk("drop_tensao", tensao_saida, 32'd10);

        // rst during WAIT, solver done arrives after release
        reset_with(1'b1);
        wait_start("rst_mid_start", 20);
        @(negedge clk);
        rst = 1'b1; run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        v0 = ov_tot;
        repeat (20) @(negedge clk);
        chk("rstmid_out_valids", 32'(ov_tot - v0), 32'd0);
        chk("rstmid_tensao", tensao_saida, 32'd0);
        chk("rstmid_corrente", corrente_saida, 32'd0);
        chk("rstmid_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rstmid_step_count", step_count, 32'd0);
        chk("rstmid_overrun", 32'(overrun), 32'd0);

        // Single-step pulses with run=0
        reset_with(1'b0);
        v0 = ov_tot; s0 = st_tot;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (18) @(negedge clk);
        end
`ifdef SIM_SINGLE_STEP_EN
        exp_steps = 3;
        exp_addr  = 8'd3;
`else
        exp_steps = 0;
        exp_addr  = 8'd0;
`endif
        chk("single_out_valids", 32'(ov_tot - v0), 32'(exp_steps));
        chk("single_starts", 32'(st_tot - s0), 32'(exp_steps));
        chk("single_rom_addr", 32'(bus.rom_addr), 32'(exp_addr));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sim_step_scheduler.md
# sim_step_scheduler

Time-step controller for the FPGA DC circuit simulator. Generates the simulation time-step from a programmable prescaler, walks the source-waveform sample ROM with wrap-around, and launches one solver operation (current = voltage / R, multi-cycle) per step. It waits for the solver handshake and publishes the step's voltage and current as registered outputs. Sits between the sample ROM, the solver and the DAC/ILA observation logic.

## Interface
- ADDR_W, 8, sample ROM address width (256 samples)
- DATA_W, 32, sample and result width
- PRESCALE_W, 16, prescaler width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = free-running steps
- step  in  1  single-step request pulse (see Configuration)
- prescale  in  PRESCALE_W  step period minus 1, in clk cycles
- end_addr  in  ADDR_W  last valid sample index
- rom_addr  out  ADDR_W  sample ROM address
- rom_data  in  DATA_W  ROM output, 1-cycle read latency
- solver_start  out  1  one-cycle start pulse
- solver_operand  out  DATA_W  source voltage sample for the solver
- solver_done  in  1  one-cycle completion pulse
- solver_result  in  DATA_W  computed current
- tensao_saida  out  DATA_W  voltage of last completed step
- corrente_saida  out  DATA_W  current of last completed step
- out_valid  out  1  one-cycle pulse on output update
- overrun  out  1  sticky: a tick arrived while a step was in progress
- step_count  out  32  completed steps, wraps at 2^32

## Operation
- Reset: state IDLE, all outputs 0, prescaler counter loaded with 0, overrun cleared.
- Tick generator: while run=1, down-counter reloads with prescale on reaching 0; tick pulses on the cycle the counter is 0. With prescale=0, tick every cycle. While run=0 the counter holds at prescale and no tick is produced.
- FSM:
  - IDLE: tick -> FETCH.
  - FETCH: rom_addr is stable; wait one cycle for rom_data -> START.
  - START: solver_start=1, solver_operand latched from rom_data -> WAIT.
  - WAIT: solver_done=1 -> COMMIT; otherwise stay.
  - COMMIT: tensao_saida <= solver_operand, corrente_saida <= solver_result, out_valid=1, step_count+1, rom_addr advances -> IDLE.
- Address: rom_addr >= end_addr at COMMIT -> 0; otherwise +1. An end_addr lowered below the current address therefore wraps at the next COMMIT.
- Tick in any state other than IDLE: the tick is dropped and overrun is set. overrun clears only on rst.
- solver_done outside WAIT is ignored.
- run deasserted mid-step: the current step completes normally. No new ticks are produced.
- prescale or end_addr changes take effect at the next reload or COMMIT; no glitch on rom_addr.
- Async rst mid-step: immediate return to IDLE with rom_addr=0 and outputs=0. A solver operation already in flight is abandoned; its later done is ignored.

## Timing
- Tick in cycle t -> FETCH t+1 -> solver_start high in t+2 -> WAIT from t+3.
- solver_done high in cycle d -> out_valid high in d+1. tensao_saida and corrente_saida change in the same cycle and then hold. New rom_addr is visible in d+2.
- Minimum step latency: 4 cycles plus solver latency. With prescale+1 < 4 + solver latency, overrun is guaranteed.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SIM_SINGLE_STEP_EN defined: when run=0 and state=IDLE, a step pulse acts as one tick (a single complete step). A step pulse while run=1 or not IDLE is ignored and does not set overrun.
- SIM_SINGLE_STEP_EN undefined: the step port is present but unused; steps occur only via run.

## Structure
- Shared package sim_pkg: FSM state enum (IDLE, FETCH, START, WAIT, COMMIT) and default widths ADDR_W, DATA_W, PRESCALE_W.
- One sub-module: sim_tick_gen (prescaler down-counter with run gating, tick output).
- FSM, address counter, output registers and overrun logic live in the top module.

## Test plan
- run=1, prescale=9, solver latency 3, ROM[0]=10 -> solver_start 2 cycles after the first tick, operand 10. out_valid 4 cycles after start with tensao_saida=10 and corrente_saida=result. Steps are 10 cycles apart.
- end_addr=3, 10 steps -> rom_addr sequence 0,1,2,3,0,1,2,3,0,1; step_count=10.
- prescale=1, solver latency 5 -> overrun=1 after the first dropped tick. Outputs still update once per completed step; overrun stays set until rst.
- run dropped while in WAIT -> that step commits (one out_valid), then no further solver_start.
- rst asserted during WAIT, solver_done pulsed after release -> all outputs 0, rom_addr=0, no out_valid.
- With SIM_SINGLE_STEP_EN, run=0, three step pulses spaced 20 cycles -> exactly 3 out_valid, rom_addr=3. Without the macro -> no solver_start.
